servo_pwm_array: RTL and testbench

//  N-channel servo PWM generator; successor to the fixed 4-servo controller. Takes a packed

---
 rtl/servo_pkg.sv | 19 +
 rtl/servo_pwm_channel.sv | 95 +++++++++
 rtl/servo_pwm_array.sv | 156 +++++++++++++++
 tb/tb_servo_pwm_array.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared defaults and angle/pulse arithmetic for the servo PWM array.
package servo_pkg;

   localparam int DEF_TICK_DIV     = 100;
   localparam int DEF_MAX_PULSE_US = 2000;
   localparam int DEF_PERIOD_US    = 20000;

   // Saturate an incoming angle field at full scale.
   function automatic int clamp_angle(input int angle, input int max_angle);
      return (angle > max_angle) ? max_angle : angle;
   endfunction

   // Linear angle-to-pulse mapping, floored.
   function automatic int width_us(input int angle, input int min_us,
                                   input int max_us, input int max_angle);
      return min_us + (angle * (max_us - min_us)) / max_angle;
   endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: slew register, per-frame pulse width, enable latch and
// staggered pulse compare against the shared microsecond counter.
module servo_pwm_channel
   import servo_pkg::*;
#(
   parameter int CH_IDX       = 0,
   parameter int ANGLE_W      = 8,
   parameter int US_W         = 15,
   parameter int MAX_ANGLE    = 180,
   parameter int MIN_PULSE_US = 1000,
   parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
   parameter int STAGGER_US   = 2500,
   parameter int SLEW_DEG     = 2,
   parameter int RESET_ANGLE  = 90
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               boundary,
   input  logic [US_W-1:0]    us_next,
   input  logic [ANGLE_W-1:0] target,
   input  logic               ch_enable,
   output logic [ANGLE_W-1:0] current,
   output logic               pwm
);

   localparam logic [ANGLE_W-1:0] SLEW_A      = ANGLE_W'(SLEW_DEG);
   localparam logic [ANGLE_W-1:0] RESET_A     = ANGLE_W'(RESET_ANGLE);
   localparam logic [US_W:0]      OFFSET      = (US_W+1)'(CH_IDX * STAGGER_US);
   localparam logic [US_W-1:0]    RESET_WIDTH =
      US_W'(width_us(RESET_ANGLE, MIN_PULSE_US, MAX_PULSE_US, MAX_ANGLE));

   logic [ANGLE_W-1:0] current_q;
   logic [US_W-1:0]    width_q;
   logic               en_q;
   logic               pwm_q;
   logic               en_d;
   logic               started;
   logic               in_window;
   logic [US_W:0]      us_ext;
   logic [US_W:0]      pulse_end;

   assign current = current_q;
   assign pwm     = pwm_q;

   // The output register looks at next-cycle counter/enable so pwm lines up
   // with us_cnt exactly; width_q only matters near the pulse end, by which
   // time it already holds this frame's width.
   assign en_d      = boundary ? ch_enable : en_q;
   assign us_ext    = {1'b0, us_next};
   assign pulse_end = OFFSET + {1'b0, width_q};

   if (CH_IDX == 0) begin : g_first
      assign started = 1'b1;
   end else begin : g_rest
      assign started = (us_ext >= OFFSET);
   end

   assign in_window = en_d && started && (us_ext < pulse_end);

   // Slew toward the pre-boundary target and latch the enable at each boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current_q <= RESET_A;
         en_q      <= 1'b0;
      end else if (boundary) begin
         en_q <= ch_enable;
         if (SLEW_DEG == 0) begin
            current_q <= target;
         end else if (current_q < target) begin
            current_q <= ((target - current_q) > SLEW_A) ? current_q + SLEW_A : target;
         end else if (current_q > target) begin
            current_q <= ((current_q - target) > SLEW_A) ? current_q - SLEW_A : target;
         end
      end
   end

   // Pulse width follows current one clock later and is then stable all frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q <= RESET_WIDTH;
      end else begin
         width_q <= US_W'(width_us(int'(current_q), MIN_PULSE_US, MAX_PULSE_US, MAX_ANGLE));
      end
   end

   // Registered pulse output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= in_window;
      end
   end

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator: microsecond timebase, double-buffered angle
// input applied at frame boundaries, per-channel slew and staggered pulses.
module servo_pwm_array
   import servo_pkg::*;
#(
   parameter int CLK_FREQ     = DEF_TICK_DIV * 1_000_000,
   parameter int NUM_SERVOS   = 6,
   parameter int ANGLE_W      = 8,
   parameter int MAX_ANGLE    = 180,
   parameter int PERIOD_US    = DEF_PERIOD_US,
   parameter int MIN_PULSE_US = 1000,
   parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
   parameter int STAGGER_US   = 2500,
   parameter int SLEW_DEG     = 2,
   parameter int RESET_ANGLE  = 90
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SERVOS*ANGLE_W-1:0] angle_flat,
   input  logic                          angle_valid,
   output logic                          angle_ready,
   input  logic [NUM_SERVOS-1:0]         ch_enable,
   output logic [NUM_SERVOS-1:0]         pwm_out,
   output logic                          frame_start,
   output logic                          busy
);

   localparam int TICK_DIV = CLK_FREQ / 1_000_000;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int US_W     = $clog2(PERIOD_US);
   localparam int FLAT_W   = NUM_SERVOS * ANGLE_W;

   localparam logic [FLAT_W-1:0] RESET_VEC = {NUM_SERVOS{ANGLE_W'(RESET_ANGLE)}};
   localparam logic [US_W-1:0]   US_LAST   = US_W'(PERIOD_US - 1);
   localparam logic [PRE_W-1:0]  PRE_LOAD  = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]  presc_q;
   logic [US_W-1:0]   us_cnt_q;
   logic [US_W-1:0]   us_d;
   logic              us_tick;
   logic              boundary;
   logic [FLAT_W-1:0] shadow_q;
   logic              shadow_full_q;
   logic [FLAT_W-1:0] target_q;
   logic [FLAT_W-1:0] clamped;
   logic [FLAT_W-1:0] cur_flat;
   logic              capture;
   logic              busy_q;
   logic              busy_d;

   assign us_tick     = (presc_q == '0);
   assign boundary    = us_tick && (us_cnt_q == US_LAST);
   assign frame_start = boundary;
   assign angle_ready = !shadow_full_q;
   assign capture     = angle_valid && angle_ready;
   assign busy        = busy_q;

   // Prescaler: down-counter reloading on terminal count, one tick per microsecond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (us_tick) begin
         presc_q <= PRE_LOAD;
      end else begin
         presc_q <= presc_q - 1'b1;
      end
   end

   // Next microsecond count, shared with the channels for their compare.
   always_comb begin
      us_d = us_cnt_q;
      if (us_tick) begin
         us_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + 1'b1;
      end
   end

   // Frame position in microseconds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt_q <= '0;
      end else begin
         us_cnt_q <= us_d;
      end
   end

   // Saturate each incoming field at full scale.
   always_comb begin
      clamped = '0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
         clamped[i*ANGLE_W +: ANGLE_W] =
            ANGLE_W'(clamp_angle(int'(angle_flat[i*ANGLE_W +: ANGLE_W]), MAX_ANGLE));
      end
   end

   // Shadow buffer and targets; a capture never coincides with a load because
   // it needs the shadow empty, so a same-cycle capture waits a whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         target_q      <= RESET_VEC;
      end else begin
         if (boundary && shadow_full_q) begin
            target_q      <= shadow_q;
            shadow_full_q <= 1'b0;
         end
         if (capture) begin
            shadow_q      <= clamped;
            shadow_full_q <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_ch
      servo_pwm_channel #(
         .CH_IDX       (g),
         .ANGLE_W      (ANGLE_W),
         .US_W         (US_W),
         .MAX_ANGLE    (MAX_ANGLE),
         .MIN_PULSE_US (MIN_PULSE_US),
         .MAX_PULSE_US (MAX_PULSE_US),
         .STAGGER_US   (STAGGER_US),
         .SLEW_DEG     (SLEW_DEG),
         .RESET_ANGLE  (RESET_ANGLE)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .boundary  (boundary),
         .us_next   (us_d),
         .target    (target_q[g*ANGLE_W +: ANGLE_W]),
         .ch_enable (ch_enable[g]),
         .current   (cur_flat[g*ANGLE_W +: ANGLE_W]),
         .pwm       (pwm_out[g])
      );
   end

   // Any channel still slewing.
   always_comb begin
      busy_d = 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
         if (cur_flat[i*ANGLE_W +: ANGLE_W] != target_q[i*ANGLE_W +: ANGLE_W]) begin
            busy_d = 1'b1;
         end
      end
   end

   // Registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench for servo_pwm_array: a frame-level model predicts every
// pulse (width and rising cycle), frame_start, busy and angle_ready.
module tb_servo_pwm_array;

   localparam int TD   = 2;
   localparam int N    = 6;
   localparam int AW   = 8;
   localparam int MAXA = 180;
   localparam int P    = 420;
   localparam int MINP = 20;
   localparam int MAXP = 60;
   localparam int STAG = 70;
   localparam int SLEW = 2;
   localparam int RSTA = 90;
   localparam int FRAME_CLK = P * TD;

   typedef struct {
      longint width;
      longint start;
   } pulse_t;

   logic          clk;
   logic          rst_n;
   logic [N*AW-1:0] angle_flat;
   logic          angle_valid;
   logic          angle_ready;
   logic [N-1:0]  ch_enable;
   logic [N-1:0]  pwm_out;
   logic          frame_start;
   logic          busy;

   servo_pwm_array #(
      .CLK_FREQ     (TD * 1_000_000),
      .NUM_SERVOS   (N),
      .ANGLE_W      (AW),
      .MAX_ANGLE    (MAXA),
      .PERIOD_US    (P),
      .MIN_PULSE_US (MINP),
      .MAX_PULSE_US (MAXP),
      .STAGGER_US   (STAG),
      .SLEW_DEG     (SLEW),
      .RESET_ANGLE  (RSTA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .angle_flat  (angle_flat),
      .angle_valid (angle_valid),
      .angle_ready (angle_ready),
      .ch_enable   (ch_enable),
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .busy        (busy)
   );

   int     vectors = 0;
   int     miscompares = 0;
   longint cyc = 0;
   longint cyc0 = 0;
   bit     running = 0;

   int     m_cur [N];
   int     m_tgt [N];
   int     m_shadow [N];
   bit     m_en [N];
   bit     m_full;
   pulse_t exp_q [N][$];

   bit     prev [N];
   longint rise [N];
   pulse_t mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_width(input int angle);
      return MINP + (angle * (MAXP - MINP)) / MAXA;
   endfunction

   // Frame-level reference model: boundary timing, handshake and slew rules.
   always @(negedge clk) begin
      if (running) begin
         longint k;
         bit     is_b;
         bit     ready_exp;
         bit     any_busy;
         k = cyc - cyc0;
         is_b = ((k % FRAME_CLK) == (P - 1) * TD);
         ready_exp = !m_full;
         if (is_b || frame_start) check("frame_start", longint'(frame_start), longint'(is_b));
         if (angle_valid) check("angle_ready", longint'(angle_ready), longint'(ready_exp));
         if (is_b) begin
            any_busy = 0;
            for (int i = 0; i < N; i++) if (m_cur[i] != m_tgt[i]) any_busy = 1;
            check("busy", longint'(busy), longint'(any_busy));
            for (int i = 0; i < N; i++) begin
               check($sformatf("ch%0d_pulses_pending", i), exp_q[i].size(), 0);
               exp_q[i].delete();
               if (SLEW == 0 || (m_tgt[i] - m_cur[i] <= SLEW && m_cur[i] - m_tgt[i] <= SLEW))
                  m_cur[i] = m_tgt[i];
               else if (m_tgt[i] > m_cur[i]) m_cur[i] += SLEW;
               else m_cur[i] -= SLEW;
               m_en[i] = ch_enable[i];
            end
            if (m_full) begin
               for (int i = 0; i < N; i++) m_tgt[i] = m_shadow[i];
               m_full = 0;
            end
            for (int i = 0; i < N; i++)
               if (m_en[i]) exp_q[i].push_back('{longint'(exp_width(m_cur[i])),
                                                 cyc + 1 + longint'(i * STAG * TD)});
         end
         if (angle_valid && ready_exp) begin
            for (int i = 0; i < N; i++) begin
               int v;
               v = int'(angle_flat[i*AW +: AW]);
               m_shadow[i] = (v > MAXA) ? MAXA : v;
            end
            m_full = 1;
         end
      end
   end

   // Monitor: measures each completed pulse and checks it against the queue.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (pwm_out[i] && !prev[i]) rise[i] = cyc;
         if (!pwm_out[i] && prev[i] && running) begin
            if (exp_q[i].size() == 0) begin
               check($sformatf("ch%0d_unexpected_pulse", i), 1, 0);
            end else begin
               mon_e = exp_q[i].pop_front();
               check($sformatf("ch%0d_width_clk", i), cyc - rise[i], mon_e.width * TD);
               check($sformatf("ch%0d_rise_cycle", i), rise[i], mon_e.start);
            end
         end
         prev[i] = pwm_out[i];
      end
   end

   function automatic logic [N*AW-1:0] rand_flat();
      logic [N*AW-1:0] f;
      for (int i = 0; i < N; i++) f[i*AW +: AW] = AW'($urandom_range(0, 255));
      return f;
   endfunction

   task automatic do_write(input logic [N*AW-1:0] data, input bit scramble);
      int n;
      n = 0;
      @(posedge clk); #1;
      angle_flat  = data;
      angle_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (angle_ready) break;
         n++;
         if (n > 3 * FRAME_CLK) begin
            check("write_accept_timeout", 0, 1);
            break;
         end
         @(posedge clk); #1;
         if (scramble) angle_flat = rand_flat();
      end
      @(posedge clk); #1;
      angle_valid = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      repeat (n * FRAME_CLK) @(posedge clk);
   endtask

   task automatic wait_high(input int ch);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pwm_out[ch] && n < 2 * FRAME_CLK);
      check($sformatf("ch%0d_pulse_seen", ch), longint'(pwm_out[ch]), 1);
   endtask

   initial begin
      rst_n       = 1'b0;
      angle_valid = 1'b0;
      angle_flat  = '0;
      ch_enable   = '0;
      for (int i = 0; i < N; i++) begin
         m_cur[i] = RSTA; m_tgt[i] = RSTA; m_shadow[i] = 0; m_en[i] = 0; prev[i] = 0; rise[i] = 0;
      end
      m_full = 0;
      repeat (3) @(posedge clk); #1;
      check("rst_pwm_out", longint'(pwm_out), 0);
      check("rst_frame_start", longint'(frame_start), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_angle_ready", longint'(angle_ready), 1);

      ch_enable = '1;
      @(posedge clk); #2;
      cyc0 = cyc;
      rst_n = 1'b1;
      running = 1;

      // 90/180/200/0/45/135: clamp, full-swing slew on ch1 and ch3
      do_write({8'd135, 8'd45, 8'd0, 8'd200, 8'd180, 8'd90}, 1'b0);
      wait_frames(48);

      // two writes in one frame: second held off until the boundary
      do_write(rand_flat(), 1'b0);
      do_write(rand_flat(), 1'b1);
      wait_frames(3);

      // random angles and enables changing at arbitrary points in the frame
      for (int r = 0; r < 4; r++) begin
         do_write(rand_flat(), 1'b1);
         repeat ($urandom_range(1, FRAME_CLK)) @(posedge clk);
         #1 ch_enable = N'($urandom);
         wait_frames($urandom_range(1, 2));
      end

      // enable dropped while ch1 is mid-pulse
      ch_enable = '1;
      wait_frames(2);
      wait_high(1);
      @(posedge clk); #1;
      ch_enable[1] = 1'b0;
      wait_frames(2);

      // asynchronous reset while ch0 is high
      wait_high(0);
      running = 0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pwm_out", longint'(pwm_out), 0);
      check("async_rst_angle_ready", longint'(angle_ready), 1);
      check("async_rst_busy", longint'(busy), 0);
      check("async_rst_frame_start", longint'(frame_start), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
